// File: rtl/iroot_pkg.sv
// rtl/iroot_pkg.sv - shared constants, state encoding and sizing functions for the integer root engine
package iroot_pkg;

   // State encodings, kept as named constants so other blocks can decode them
   localparam logic [2:0] ENC_IDLE  = 3'd0;
   localparam logic [2:0] ENC_INIT  = 3'd1;
   localparam logic [2:0] ENC_SHIFT = 3'd2;
   localparam logic [2:0] ENC_MUL   = 3'd3;
   localparam logic [2:0] ENC_BUILD = 3'd4;
   localparam logic [2:0] ENC_TEST  = 3'd5;
   localparam logic [2:0] ENC_DONE  = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE  = ENC_IDLE,
      ST_INIT  = ENC_INIT,
      ST_SHIFT = ENC_SHIFT,
      ST_MUL   = ENC_MUL,
      ST_BUILD = ENC_BUILD,
      ST_TEST  = ENC_TEST,
      ST_DONE  = ENC_DONE
   } state_t;

   localparam logic MODE_SQRT = 1'b0;
   localparam logic MODE_CBRT = 1'b1;

   // Shift counter width: largest start shift is 30 (WIDTH=32)
   localparam int SW = 6;

   // Square-root iterations: one result bit per pair of operand bits
   function automatic int n2_f(input int w);
      return (w + 1) / 2;
   endfunction

   // Cube-root iterations: one result bit per triple of operand bits
   function automatic int n3_f(input int w);
      return (w + 2) / 3;
   endfunction

   // Root output width is set by the square root, the wider of the two
   function automatic int rw_f(input int w);
      return n2_f(w);
   endfunction

   // Multiplier operand width: the cube partial root plus one bit for y+1
   function automatic int mw_f(input int w);
      return n3_f(w) + 1;
   endfunction

endpackage

// File: rtl/iroot_seq_if.sv
// rtl/iroot_seq_if.sv - request/result handshake bundle of the integer root engine
interface iroot_seq_if #(
   parameter int WIDTH = 16
);
   import iroot_pkg::*;

   localparam int RW = rw_f(WIDTH);

   logic             start_i;
   logic             mode_i;
   logic [WIDTH-1:0] x_i;
   logic             ready_o;
   logic             valid_o;
   logic [RW-1:0]    root_o;
   logic [WIDTH-1:0] rem_o;

   modport master (
      output start_i, mode_i, x_i,
      input  ready_o, valid_o, root_o, rem_o
   );

   modport slave (
      input  start_i, mode_i, x_i,
      output ready_o, valid_o, root_o, rem_o
   );

endinterface

// File: rtl/iroot_seq_mul.sv
// rtl/iroot_seq_mul.sv - sequential shift-add multiplier, busy for exactly W cycles per product
module mul_seq #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic           busy_o,
   output logic [2*W-1:0] prod_o
);
   localparam int CW = $clog2(W + 1);

   logic [CW-1:0]  cnt_q;
   logic [2*W-1:0] mcand_q;
   logic [W-1:0]   mplier_q;
   logic [2*W-1:0] acc_q;

   // One multiplier bit per cycle: add the shifted multiplicand when the low bit is set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start_i) begin
         cnt_q    <= CW'(W);
         mcand_q  <= {{W{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
      end else if (cnt_q != '0) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[W-1:1]};
         cnt_q    <= cnt_q - CW'(1);
      end
   end

   assign busy_o = (cnt_q != '0);
   assign prod_o = acc_q;

endmodule

// File: rtl/iroot_seq.sv
// rtl/iroot_seq.sv - sequential restoring square/cube root engine with remainder
module iroot_seq
   import iroot_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   iroot_seq_if.slave bus
);
   localparam int N2 = n2_f(WIDTH);
   localparam int N3 = n3_f(WIDTH);
   localparam int RW = rw_f(WIDTH);
   localparam int MW = mw_f(WIDTH);
   localparam int BW = 2 * WIDTH + 2;
   localparam int CW = $clog2(MW + 1);

   localparam logic [SW-1:0] S2_INIT = SW'(2 * (N2 - 1));
   localparam logic [SW-1:0] S3_INIT = SW'(3 * (N3 - 1));

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [RW-1:0]    y_q, y_d;
   logic [SW-1:0]    s_q, s_d;
   logic             mode_q, mode_d;
   logic [BW-1:0]    b_q, b_d;
   logic [CW-1:0]    mwait_q, mwait_d;
   logic [RW-1:0]    root_q, root_d;
   logic [WIDTH-1:0] rem_q, rem_d;

   logic [RW-1:0]    y_sh;
   logic             mul_start;
   logic [MW-1:0]    mul_a;
   logic [MW-1:0]    mul_b;
   logic             mul_busy;
   logic [2*MW-1:0]  mul_prod;

   // y(y+1) for the cube bound; y is already doubled when the multiplier starts
   mul_seq #(.W(MW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (mul_start),
      .a_i     (mul_a),
      .b_i     (mul_b),
      .busy_o  (mul_busy),
      .prod_o  (mul_prod)
   );

   assign y_sh  = {y_q[RW-2:0], 1'b0};
   assign mul_a = MW'(y_sh);
   assign mul_b = MW'(y_sh) + MW'(1);

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         y_q     <= '0;
         s_q     <= '0;
         mode_q  <= MODE_SQRT;
         b_q     <= '0;
         mwait_q <= '0;
         root_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         y_q     <= y_d;
         s_q     <= s_d;
         mode_q  <= mode_d;
         b_q     <= b_d;
         mwait_q <= mwait_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
      end
   end

   // Next-state and datapath: one root bit per SHIFT/[MUL]/BUILD/TEST pass
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      y_d       = y_q;
      s_d       = s_q;
      mode_d    = mode_q;
      b_d       = b_q;
      mwait_d   = mwait_q;
      root_d    = root_q;
      rem_d     = rem_q;
      mul_start = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               // operand and mode are captured at accept so the requester may move on
               mode_d  = bus.mode_i;
               r_d     = bus.x_i;
               y_d     = '0;
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            y_d     = '0;
            s_d     = (mode_q == MODE_CBRT) ? S3_INIT : S2_INIT;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            y_d = y_sh;
            if (mode_q == MODE_CBRT) begin
               mul_start = 1'b1;
               mwait_d   = CW'(MW - 1);
               state_d   = ST_MUL;
            end else begin
               state_d = ST_BUILD;
            end
         end
         ST_MUL: begin
            // counts the multiplier's busy window so BUILD lands on the first idle cycle
            if (mwait_q == '0) begin
               state_d = ST_BUILD;
            end else begin
               mwait_d = mwait_q - CW'(1);
            end
         end
         ST_BUILD: begin
            if (mode_q == MODE_CBRT) begin
               b_d = ((BW'(mul_prod) << 1) + BW'(mul_prod) + BW'(1)) << s_q;
            end else begin
               b_d = BW'({y_q, 1'b1}) << s_q;
            end
            state_d = ST_TEST;
         end
         ST_TEST: begin
            if (BW'(r_q) >= b_q) begin
               r_d = r_q - b_q[WIDTH-1:0];
               y_d = y_q + RW'(1);
            end
            if (s_q == '0) begin
               // results are registered on entry to DONE so they accompany valid_o
               root_d  = y_d;
               rem_d   = r_d;
               state_d = ST_DONE;
            end else begin
               s_d     = s_q - ((mode_q == MODE_CBRT) ? SW'(3) : SW'(2));
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.ready_o = (state_q == ST_IDLE);
   assign bus.valid_o = (state_q == ST_DONE);
   assign bus.root_o  = root_q;
   assign bus.rem_o   = rem_q;

endmodule

// File: tb/tb_iroot_seq.sv
// tb/tb_iroot_seq.sv - directed and model-checked bench for the integer root engine
module tb_iroot_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   iroot_seq_if #(.WIDTH(16)) b16 ();
   iroot_seq_if #(.WIDTH(3))  b3 ();
   iroot_seq_if #(.WIDTH(32)) b32 ();

   iroot_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
   iroot_seq #(.WIDTH(3))  u3  (.clk(clk), .rst(rst), .bus(b3));
   iroot_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

   logic [2:0]  st = '0;
   logic [2:0]  md = '0;
   logic [31:0] xv [3];
   logic [2:0]  rdy, vld;
   logic [31:0] root_w [3];
   logic [31:0] rem_w  [3];

   assign b16.start_i = st[0];
   assign b16.mode_i  = md[0];
   assign b16.x_i     = xv[0][15:0];
   assign b3.start_i  = st[1];
   assign b3.mode_i   = md[1];
   assign b3.x_i      = xv[1][2:0];
   assign b32.start_i = st[2];
   assign b32.mode_i  = md[2];
   assign b32.x_i     = xv[2];

   assign rdy[0] = b16.ready_o;
   assign vld[0] = b16.valid_o;
   assign root_w[0] = 32'(b16.root_o);
   assign rem_w[0]  = 32'(b16.rem_o);
   assign rdy[1] = b3.ready_o;
   assign vld[1] = b3.valid_o;
   assign root_w[1] = 32'(b3.root_o);
   assign rem_w[1]  = 32'(b3.rem_o);
   assign rdy[2] = b32.ready_o;
   assign vld[2] = b32.valid_o;
   assign root_w[2] = 32'(b32.root_o);
   assign rem_w[2]  = 32'(b32.rem_o);

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Independent reference: largest y whose square/cube does not exceed x
   function automatic void ref_root(input longint unsigned x, input bit m,
                                    output longint unsigned y, output longint unsigned rem);
      longint unsigned t;
      y = 0;
      forever begin
         t = y + 1;
         if ((m ? t * t * t : t * t) > x) break;
         y = t;
      end
      rem = x - (m ? y * y * y : y * y);
   endfunction

   // One request on unit u; checks latency from accept, result, and return to ready
   task automatic run(input int u, input bit m, input logic [31:0] x,
                      input logic [31:0] er, input logic [31:0] erem, input int elat,
                      input string nm);
      int t;
      int cyc;
      t = 0;
      while (!rdy[u] && t < 400) begin
         @(posedge clk); #1; t++;
      end
      check({nm, " ready"}, longint'(rdy[u]), 1);
      st[u] = 1'b1; md[u] = m; xv[u] = x;
      @(posedge clk); #1;
      st[u] = 1'b0; md[u] = ~m; xv[u] = 32'hFFFF_FFFF;
      cyc = 1;
      while (!vld[u] && cyc < 400) begin
         @(posedge clk); #1; cyc++;
      end
      check({nm, " latency"}, cyc, elat);
      check({nm, " root"}, root_w[u], er);
      check({nm, " rem"}, rem_w[u], erem);
      @(posedge clk); #1;
      check({nm, " valid drop"}, longint'(vld[u]), 0);
      check({nm, " ready back"}, longint'(rdy[u]), 1);
   endtask

   typedef struct {
      bit          m;
      logic [31:0] x;
      logic [31:0] root;
      logic [31:0] rem;
      int          lat;
   } vec_t;

   vec_t vt [8];

   initial begin
      longint unsigned er, erem;
      logic [31:0] rx;

      vt[0] = '{1'b0, 32'd200,   32'd14,  32'd4,    26};
      vt[1] = '{1'b1, 32'd999,   32'd9,   32'd270,  62};
      vt[2] = '{1'b1, 32'd1000,  32'd10,  32'd0,    62};
      vt[3] = '{1'b0, 32'd65535, 32'd255, 32'd510,  26};
      vt[4] = '{1'b1, 32'd65535, 32'd40,  32'd1535, 62};
      vt[5] = '{1'b0, 32'd0,     32'd0,   32'd0,    26};
      vt[6] = '{1'b1, 32'd0,     32'd0,   32'd0,    62};
      vt[7] = '{1'b1, 32'd27,    32'd3,   32'd0,    62};
      for (int i = 0; i < 3; i++) xv[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         check($sformatf("reset ready u%0d", u), longint'(rdy[u]), 1);
         check($sformatf("reset valid u%0d", u), longint'(vld[u]), 0);
         check($sformatf("reset root u%0d", u), root_w[u], 0);
         check($sformatf("reset rem u%0d", u), rem_w[u], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         run(0, vt[i].m, vt[i].x, vt[i].root, vt[i].rem, vt[i].lat, $sformatf("w16 vec%0d", i));

      // Back-to-back: start held high, mode alternating, one accept per L+1 cycles
      begin
         bit          pm [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
         logic [31:0] px [4]  = '{32'd200, 32'd1000, 32'd65535, 32'd999};
         logic [31:0] pr [4]  = '{32'd14, 32'd10, 32'd255, 32'd9};
         logic [31:0] pe [4]  = '{32'd4, 32'd0, 32'd510, 32'd270};
         int          pl [4]  = '{26, 62, 26, 62};
         int acc, res, acc_c, prev_c;
         bit going;
         acc = 0; res = 0; acc_c = 0; prev_c = -1;
         st[0] = 1'b1; md[0] = pm[0]; xv[0] = px[0];
         for (int c = 0; c < 400 && res < 5; c++) begin
            if (vld[0]) begin
               if (res < 4) begin
                  check($sformatf("b2b root %0d", res), root_w[0], pr[res]);
                  check($sformatf("b2b rem %0d", res), rem_w[0], pe[res]);
                  check($sformatf("b2b latency %0d", res), c - acc_c, pl[res]);
               end else begin
                  check("b2b extra valid", 1, 0);
               end
               res++;
            end
            going = rdy[0] && st[0];
            if (going) begin
               if (prev_c >= 0)
                  check($sformatf("b2b accept gap %0d", acc), c - prev_c, pl[acc - 1] + 1);
               prev_c = c;
               acc_c  = c;
            end
            @(posedge clk); #1;
            if (going) begin
               acc++;
               if (acc < 4) begin
                  md[0] = pm[acc]; xv[0] = px[acc];
               end else begin
                  st[0] = 1'b0;
               end
            end
            if (acc == 4 && res == 4 && c > acc_c + 70) break;
         end
         check("b2b results", res, 4);
      end

      // Reset while the multiplier is running
      @(posedge clk); #1;
      st[0] = 1'b1; md[0] = 1'b1; xv[0] = 32'd999;
      @(posedge clk); #1;
      st[0] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("abort ready", longint'(rdy[0]), 1);
      check("abort valid", longint'(vld[0]), 0);
      check("abort root", root_w[0], 0);
      check("abort rem", rem_w[0], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      begin
         int pulses;
         pulses = 0;
         for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (vld[0]) pulses++;
         end
         check("abort no valid", pulses, 0);
      end
      run(0, 1'b1, 32'd27, 32'd3, 32'd0, 62, "w16 after abort");

      // WIDTH=3 exhaustive in both modes
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 8; x++) begin
            ref_root(longint'(x), m[0], er, erem);
            run(1, m[0], 32'(x), 32'(er), 32'(erem), m ? 7 : 8, $sformatf("w3 m%0d x%0d", m, x));
         end
      end

      // WIDTH=32 extremes and a few random operands
      run(2, 1'b0, 32'hFFFF_FFFF, 32'd65535, 32'd131070, 50, "w32 sqrt max");
      run(2, 1'b1, 32'hFFFF_FFFF, 32'd1625, 32'd3951670, 167, "w32 cbrt max");
      for (int i = 0; i < 6; i++) begin
         rx = $urandom;
         ref_root(longint'(rx), i[0], er, erem);
         run(2, i[0], rx, 32'(er), 32'(erem), i[0] ? 167 : 50, $sformatf("w32 rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
